data_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the data bus controller, sharing its single bus port between the core load/store unit (port 0) and the debug/loader port (port 1). It accepts one request at a time and drives the controller's read and write strobes in the order the controller requires. For sub-word writes this means a pre-read cycle before the write strobe. It returns read data and completion pulses to the winning requester.

---
 rtl/data_bus_arbiter_pkg.sv | 38 +++
 rtl/data_bus_arbiter_if.sv | 36 +++
 rtl/data_bus_arbiter_rr_pick2.sv | 15 +
 rtl/data_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter: size codes, FSM state encoding,
// command record and the read-latency bound that sizes the latency counter.
package data_bus_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int READ_LATENCY_MAX = 7;
   localparam int CNT_W            = $clog2(READ_LATENCY_MAX + 1);

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ISSUE  = 2'd1,
      ARB_RDWAIT = 2'd2,
      ARB_WRITE  = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } arb_cmd_t;

   // The reserved code 11 behaves as a full word on the bus.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      logic [1:0] result;
      case (size)
         SIZE_BYTE: result = SIZE_BYTE;
         SIZE_HALF: result = SIZE_HALF;
         default:   result = SIZE_WORD;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester-side and controller-side signals of the data bus arbiter.
// slave = the arbiter's view, master = the surrounding system's view.
interface data_bus_arbiter_if;
   logic        m0_req,   m1_req;
   logic        m0_we,    m1_we;
   logic [1:0]  m0_size,  m1_size;
   logic [31:0] m0_addr,  m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_grant, m1_grant;
   logic        m0_done,  m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        bus_ready;
   logic        bus_rd,   bus_wd;
   logic [1:0]  bus_size_in,  bus_size_out;
   logic [31:0] bus_addr_in,  bus_addr_out;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_size, m1_size,
      input  m0_addr, m1_addr, m0_wdata, m1_wdata,
      output m0_grant, m1_grant, m0_done, m1_done, m0_rdata, m1_rdata,
      input  bus_ready, bus_rdata,
      output bus_rd, bus_wd, bus_size_in, bus_size_out,
      output bus_addr_in, bus_addr_out, bus_wdata
   );

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_size, m1_size,
      output m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  m0_grant, m1_grant, m0_done, m1_done, m0_rdata, m1_rdata,
      output bus_ready, bus_rdata,
      input  bus_rd, bus_wd, bus_size_in, bus_size_out,
      input  bus_addr_in, bus_addr_out, bus_wdata
   );
endinterface

// File: rtl/data_bus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker producing a one-hot winner. On a tie the
// port other than i_last wins, or port 0 whenever i_fixed is set.
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_fixed,
   output logic [1:0] o_win
);
   always_comb begin
      o_win = i_req;
      if (i_req == 2'b11) begin
         o_win = (i_fixed || i_last) ? 2'b01 : 2'b10;
      end
   end
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one bus-controller port between two requesters, issuing reads
// and pre-read/write pairs. Define DATA_BUS_ARBITER_FIXED_PRIORITY_EN for fixed priority.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int READ_LATENCY = 1   // 1 .. READ_LATENCY_MAX
)(
   input  logic              clk,
   input  logic              rst,
   data_bus_arbiter_if.slave arb
);
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_t       r_state, w_state_next;
   arb_cmd_t         r_cmd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_m0_grant, r_m1_grant, r_m0_done, r_m1_done;
   logic [31:0]      r_m0_rdata, r_m1_rdata;
   logic [1:0]       w_req, w_win;
   logic             w_last, w_fixed, w_accept, w_rd_last, w_finish;
   logic             w_bus_rd, w_bus_wd;
   logic [1:0]       w_size_in, w_size_out;
   logic [31:0]      w_addr_in, w_addr_out, w_wdata;

`ifdef DATA_BUS_ARBITER_FIXED_PRIORITY_EN
   assign w_last  = 1'b0;
   assign w_fixed = 1'b1;
`else
   logic r_last;
   // Reset value 1 lets port 0 win the first tie.
   always_ff @(posedge clk) begin
      if (rst)           r_last <= 1'b1;
      else if (w_accept) r_last <= w_win[1];
   end
   assign w_last  = r_last;
   assign w_fixed = 1'b0;
`endif

   assign w_req = {arb.m1_req, arb.m0_req};

   rr_pick2 u_pick (
      .i_req   (w_req),
      .i_last  (w_last),
      .i_fixed (w_fixed),
      .o_win   (w_win)
   );

   assign w_accept  = (r_state == ARB_IDLE) && arb.bus_ready && (|w_req);
   assign w_rd_last = (r_state == ARB_RDWAIT) && (r_cnt == CNT_ONE);
   assign w_finish  = w_rd_last || (r_state == ARB_WRITE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ARB_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:   if (w_accept) w_state_next = ARB_ISSUE;
         ARB_ISSUE:  w_state_next = r_cmd.we ? ARB_WRITE : ARB_RDWAIT;
         ARB_RDWAIT: if (r_cnt == CNT_ONE) w_state_next = ARB_IDLE;
         ARB_WRITE:  w_state_next = ARB_IDLE;
         default:    w_state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      w_bus_rd   = 1'b0;
      w_bus_wd   = 1'b0;
      w_size_in  = 2'b00;
      w_size_out = 2'b00;
      w_addr_in  = 32'h0;
      w_addr_out = 32'h0;
      w_wdata    = 32'h0;
      if (r_state != ARB_IDLE) begin
         if (r_cmd.we) begin
            // ISSUE is the pre-read: write side presented, strobe held back one cycle.
            w_size_in = r_cmd.size;
            w_addr_in = r_cmd.addr;
            w_wdata   = r_cmd.wdata;
            w_bus_wd  = (r_state == ARB_WRITE);
         end else begin
            w_bus_rd   = 1'b1;
            w_size_out = r_cmd.size;
            w_addr_out = r_cmd.addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd <= '0;
         r_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_cmd.port  <= w_win[1];
            r_cmd.we    <= w_win[1] ? arb.m1_we : arb.m0_we;
            r_cmd.size  <= norm_size(w_win[1] ? arb.m1_size : arb.m0_size);
            r_cmd.addr  <= w_win[1] ? arb.m1_addr : arb.m0_addr;
            r_cmd.wdata <= w_win[1] ? arb.m1_wdata : arb.m0_wdata;
         end
         if (r_state == ARB_ISSUE && !r_cmd.we) r_cnt <= LAT_INIT;
         else if (r_state == ARB_RDWAIT)        r_cnt <= r_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m0_grant <= 1'b0;
         r_m1_grant <= 1'b0;
         r_m0_done  <= 1'b0;
         r_m1_done  <= 1'b0;
         r_m0_rdata <= 32'h0;
         r_m1_rdata <= 32'h0;
      end else begin
         r_m0_grant <= w_accept && w_win[0];
         r_m1_grant <= w_accept && w_win[1];
         r_m0_done  <= w_finish && !r_cmd.port;
         r_m1_done  <= w_finish && r_cmd.port;
         if (w_rd_last && !r_cmd.port) r_m0_rdata <= arb.bus_rdata;
         if (w_rd_last && r_cmd.port)  r_m1_rdata <= arb.bus_rdata;
      end
   end

   assign arb.m0_grant     = r_m0_grant;
   assign arb.m1_grant     = r_m1_grant;
   assign arb.m0_done      = r_m0_done;
   assign arb.m1_done      = r_m1_done;
   assign arb.m0_rdata     = r_m0_rdata;
   assign arb.m1_rdata     = r_m1_rdata;
   assign arb.bus_rd       = w_bus_rd;
   assign arb.bus_wd       = w_bus_wd;
   assign arb.bus_size_in  = w_size_in;
   assign arb.bus_size_out = w_size_out;
   assign arb.bus_addr_in  = w_addr_in;
   assign arb.bus_addr_out = w_addr_out;
   assign arb.bus_wdata    = w_wdata;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a vector table of single accesses, hand-written corner
// sequences, and a randomized run checked against a transaction-timeline model.
module tb_data_bus_arbiter;
   localparam int LAT  = 1;
   localparam int LAT3 = 3;
`ifdef DATA_BUS_ARBITER_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct packed {
      logic        g0, g1, d0, d1, rd, wd;
      logic [1:0]  size_in, size_out;
      logic [31:0] addr_in, addr_out, wdata, rdata0, rdata1;
   } obs_t;

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  exp_size;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   data_bus_arbiter_if arb_if ();
   data_bus_arbiter_if arb3_if ();

   data_bus_arbiter #(.READ_LATENCY(LAT))  u_dut  (.clk(clk), .rst(rst), .arb(arb_if));
   data_bus_arbiter #(.READ_LATENCY(LAT3)) u_dut3 (.clk(clk), .rst(rst), .arb(arb3_if));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t sample1();
      obs_t o;
      o.g0       = arb_if.m0_grant;
      o.g1       = arb_if.m1_grant;
      o.d0       = arb_if.m0_done;
      o.d1       = arb_if.m1_done;
      o.rd       = arb_if.bus_rd;
      o.wd       = arb_if.bus_wd;
      o.size_in  = arb_if.bus_size_in;
      o.size_out = arb_if.bus_size_out;
      o.addr_in  = arb_if.bus_addr_in;
      o.addr_out = arb_if.bus_addr_out;
      o.wdata    = arb_if.bus_wdata;
      o.rdata0   = arb_if.m0_rdata;
      o.rdata1   = arb_if.m1_rdata;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("g=%b%b d=%b%b rd=%b wd=%b szi=%0d szo=%0d ai=%h ao=%h wdat=%h r0=%h r1=%h",
                       o.g0, o.g1, o.d0, o.d1, o.rd, o.wd, o.size_in, o.size_out,
                       o.addr_in, o.addr_out, o.wdata, o.rdata0, o.rdata1);
   endfunction

   task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {%s} need {%s}", name, fmt(got), fmt(exp));
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h need %h", name, got, exp);
      end
   endtask

   function automatic obs_t idle_obs(input logic [31:0] r0, input logic [31:0] r1);
      obs_t e = '0;
      e.rdata0 = r0;
      e.rdata1 = r1;
      return e;
   endfunction

   // Expected outputs d cycles after the cycle in which the request was accepted.
   function automatic obs_t exp_txn(input txn_t t, input int d, input int lat,
                                    input logic [31:0] r0, input logic [31:0] r1);
      obs_t e = idle_obs(r0, r1);
      if (d == 1) begin
         e.g0 = !t.port;
         e.g1 = t.port;
      end
      if (t.we) begin
         if (d == 1 || d == 2) begin
            e.addr_in = t.addr;
            e.size_in = t.size;
            e.wdata   = t.wdata;
         end
         e.wd = (d == 2);
         if (d == 3) begin
            e.d0 = !t.port;
            e.d1 = t.port;
         end
      end else begin
         if (d >= 1 && d <= 1 + lat) begin
            e.rd       = 1'b1;
            e.addr_out = t.addr;
            e.size_out = t.size;
         end
         if (d == 2 + lat) begin
            e.d0 = !t.port;
            e.d1 = t.port;
         end
      end
      return e;
   endfunction

   task automatic set_req(input int p, input logic req, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (p == 1) begin
         arb_if.m1_req = req; arb_if.m1_we = we; arb_if.m1_size = size;
         arb_if.m1_addr = addr; arb_if.m1_wdata = wdata;
      end else begin
         arb_if.m0_req = req; arb_if.m0_we = we; arb_if.m0_size = size;
         arb_if.m0_addr = addr; arb_if.m0_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      arb_if.bus_ready = 1'b1;
      arb_if.bus_rdata = 32'h0;
      arb3_if.m0_req = 1'b0; arb3_if.m0_we = 1'b0; arb3_if.m0_size = 2'b00;
      arb3_if.m0_addr = 32'h0; arb3_if.m0_wdata = 32'h0;
      arb3_if.m1_req = 1'b0; arb3_if.m1_we = 1'b0; arb3_if.m1_size = 2'b00;
      arb3_if.m1_addr = 32'h0; arb3_if.m1_wdata = 32'h0;
      arb3_if.bus_ready = 1'b1;
      arb3_if.bus_rdata = 32'h0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_random(input int ncyc);
      txn_t        cur;
      txn_t        preq[2];
      bit          pend[2];
      bit          active;
      int          t_acc, d, dur, w;
      logic        m_last;
      logic [31:0] m_r[2];
      obs_t        e;
      do_reset();
      cur = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0};
      preq[0] = cur;
      preq[1] = cur;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      active = 1'b0;
      t_acc = 0;
      m_last = 1'b1;
      m_r[0] = 32'h0;
      m_r[1] = 32'h0;
      for (int c = 0; c < ncyc; c++) begin
         d   = c - t_acc;
         dur = cur.we ? 3 : 2 + LAT;
         e   = active ? exp_txn(cur, d, LAT, m_r[0], m_r[1]) : idle_obs(m_r[0], m_r[1]);
         chk_obs($sformatf("random c%0d", c), sample1(), e);
         if (e.g0) pend[0] = 1'b0;
         if (e.g1) pend[1] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               preq[p].port  = 1'(p);
               preq[p].we    = 1'($urandom_range(0, 1));
               preq[p].size  = 2'($urandom_range(0, 3));
               preq[p].addr  = $urandom;
               preq[p].wdata = $urandom;
               pend[p] = 1'b1;
            end
            set_req(p, pend[p], preq[p].we, preq[p].size, preq[p].addr, preq[p].wdata);
         end
         arb_if.bus_ready = ($urandom_range(0, 3) != 0);
         arb_if.bus_rdata = $urandom;
         if (active && !cur.we && d == 1 + LAT) m_r[cur.port] = arb_if.bus_rdata;
         if (active && d >= dur) active = 1'b0;
         if (!active && arb_if.bus_ready && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) w = (FIXED || m_last) ? 0 : 1;
            else                    w = pend[1] ? 1 : 0;
            cur = preq[w];
            cur.size = (preq[w].size == 2'b11) ? 2'b10 : preq[w].size;
            t_acc  = c;
            active = 1'b1;
            m_last = 1'(w);
         end
         tick();
      end
   endtask

   initial begin
      vec_t        vt[5];
      txn_t        t;
      logic [31:0] exp_r[2];
      obs_t        o;
      int          ng, prev;

      vt[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2'b10};
      vt[1] = '{1'b1, 1'b1, 2'b00, 32'h0000_0204, 32'h0000_0055, 32'h0,         2'b00};
      vt[2] = '{1'b1, 1'b0, 2'b11, 32'h0000_03FC, 32'h0,         32'h1234_5678, 2'b10};
      vt[3] = '{1'b0, 1'b1, 2'b01, 32'h0000_0802, 32'h0000_BEEF, 32'h0,         2'b01};
      vt[4] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0,         2'b10};

      do_reset();
      chk_obs("reset", sample1(), '0);
      chk("reset_dut3", {30'h0, arb3_if.m0_grant, arb3_if.bus_rd}, 32'h0);

      // Single accesses from idle, each followed by a quiet cycle.
      exp_r[0] = 32'h0;
      exp_r[1] = 32'h0;
      foreach (vt[i]) begin
         t = '{vt[i].port, vt[i].we, vt[i].exp_size, vt[i].addr, vt[i].wdata};
         set_req(int'(vt[i].port), 1'b1, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata);
         arb_if.bus_ready = 1'b1;
         arb_if.bus_rdata = ~vt[i].rdata;
         tick();
         for (int d = 1; d <= 4; d++) begin
            chk_obs($sformatf("vec%0d d%0d", i, d), sample1(),
                    exp_txn(t, d, LAT, exp_r[0], exp_r[1]));
            if (d == 1) set_req(int'(vt[i].port), 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            arb_if.bus_rdata = (d == 1 + LAT) ? vt[i].rdata : ~vt[i].rdata;
            if (!vt[i].we && d == 1 + LAT) exp_r[vt[i].port] = vt[i].rdata;
            tick();
         end
      end

      // Contention: both ports request reads continuously.
      do_reset();
      set_req(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
      set_req(1, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
      ng = 0;
      prev = 0;
      for (int c = 1; c <= 30 && ng < 4; c++) begin
         tick();
         if (arb_if.m0_grant || arb_if.m1_grant) begin
            chk($sformatf("contend_port%0d", ng), {31'h0, arb_if.m1_grant},
                FIXED ? 32'h0 : 32'(ng % 2));
            chk($sformatf("contend_onehot%0d", ng), {31'h0, arb_if.m0_grant & arb_if.m1_grant}, 32'h0);
            if (ng > 0) chk($sformatf("contend_gap%0d", ng), 32'(c - prev), 32'd3);
            prev = c;
            ng++;
         end
      end
      chk("contend_count", 32'(ng), 32'd4);
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (4) tick();

      // Backpressure: bus_ready low for four cycles with m0 pending.
      arb_if.bus_ready = 1'b0;
      set_req(0, 1'b1, 1'b0, 2'b10, 32'h400, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         o = sample1();
         chk($sformatf("bp_quiet%0d", c), {28'h0, o.g0, o.g1, o.rd, o.wd}, 32'h0);
         if (c == 4) arb_if.bus_ready = 1'b1;
      end
      tick();
      chk("bp_grant", {30'h0, arb_if.m0_grant, arb_if.bus_rd}, 32'h3);
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (3) tick();

      // Reset while in RDWAIT, then an m1-only read.
      arb_if.bus_rdata = 32'hA5A5_5A5A;
      set_req(0, 1'b1, 1'b0, 2'b10, 32'h500, 32'h0);
      tick();
      chk("rstmid_grant", {31'h0, arb_if.m0_grant}, 32'h1);
      set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      tick();
      chk("rstmid_rdwait", {31'h0, arb_if.bus_rd}, 32'h1);
      rst = 1'b1;
      tick();
      chk_obs("rstmid_cleared", sample1(), '0);
      rst = 1'b0;
      set_req(1, 1'b1, 1'b0, 2'b10, 32'h600, 32'h0);
      tick();
      chk("rstmid_m1_grant", {30'h0, arb_if.m0_grant, arb_if.m1_grant}, 32'h1);
      chk("rstmid_no_done", {30'h0, arb_if.m0_done, arb_if.m1_done}, 32'h0);
      set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      arb_if.bus_rdata = 32'h600D_CAFE;
      tick();
      tick();
      chk("rstmid_m1_done", {30'h0, arb_if.m0_done, arb_if.m1_done}, 32'h1);
      chk("rstmid_m1_rdata", arb_if.m1_rdata, 32'h600D_CAFE);
      tick();

      // READ_LATENCY = 3 instance.
      arb3_if.bus_ready = 1'b1;
      arb3_if.bus_rdata = 32'h1111_1111;
      arb3_if.m0_req = 1'b1; arb3_if.m0_we = 1'b0; arb3_if.m0_size = 2'b01;
      arb3_if.m0_addr = 32'h700;
      tick();
      for (int d = 1; d <= 6; d++) begin
         chk($sformatf("lat3_rd d%0d", d), {31'h0, arb3_if.bus_rd}, 32'(d >= 1 && d <= 4));
         chk($sformatf("lat3_grant d%0d", d), {31'h0, arb3_if.m0_grant}, 32'(d == 1));
         chk($sformatf("lat3_done d%0d", d), {31'h0, arb3_if.m0_done}, 32'(d == 5));
         chk($sformatf("lat3_addr d%0d", d), arb3_if.bus_addr_out, (d <= 4) ? 32'h700 : 32'h0);
         if (d == 5) chk("lat3_rdata", arb3_if.m0_rdata, 32'hC0FF_EE00);
         if (d == 1) arb3_if.m0_req = 1'b0;
         arb3_if.bus_rdata = (d == 4) ? 32'hC0FF_EE00 : 32'h1111_1111;
         tick();
      end

      run_random(600);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
